// File: rtl/arb8way16_pkg.sv
// Shared types, sizes and the round-robin search used by the arb8way16 arbiter.
package arb8way16_pkg;

   localparam int NUM_PORTS = 8;
   localparam int DATA_W    = 16;
   localparam int SEL_W     = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } rr_pick_t;

   // First set request bit strictly after ptr, wrapping; ptr itself is checked last.
   function automatic rr_pick_t rr_next(input logic [SEL_W-1:0]     ptr,
                                        input logic [NUM_PORTS-1:0] req);
      rr_pick_t         pick;
      logic [SEL_W-1:0] cand;
      pick = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         cand = ptr + SEL_W'(k);
         if (!pick.found && req[cand]) begin
            pick.found = 1'b1;
            pick.idx   = cand;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/arb8way16_mux.sv
// Existing combinational 8-input, 16-bit multiplexer (module mux8way16).
module mux8way16
   import arb8way16_pkg::*;
(
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic [DATA_W-1:0] i_c,
   input  logic [DATA_W-1:0] i_d,
   input  logic [DATA_W-1:0] i_e,
   input  logic [DATA_W-1:0] i_f,
   input  logic [DATA_W-1:0] i_g,
   input  logic [DATA_W-1:0] i_h,
   input  logic [SEL_W-1:0]  i_sel,
   output logic [DATA_W-1:0] o_y
);

   always_comb begin
      o_y = '0;
      case (i_sel)
         3'd0:    o_y = i_a;
         3'd1:    o_y = i_b;
         3'd2:    o_y = i_c;
         3'd3:    o_y = i_d;
         3'd4:    o_y = i_e;
         3'd5:    o_y = i_f;
         3'd6:    o_y = i_g;
         3'd7:    o_y = i_h;
         default: o_y = '0;
      endcase
   end

endmodule

// File: rtl/arb8way16.sv
// Round-robin 8-way burst arbiter onto one 16-bit valid/ready channel.
// Optional per-grant beat limit is built when ARB8WAY16_BURST_LIMIT_EN is defined.
//
// state | meaning
// IDLE  | no grant; search for next requester after ptr
// GRANT | port sel owns the channel until last, req drop or beat limit
module arb8way16
   import arb8way16_pkg::*;
#(
   parameter int MAX_BEATS = 16
)(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [NUM_PORTS-1:0] i_req,
   input  logic [NUM_PORTS-1:0] i_last,
   input  logic [DATA_W-1:0]    i_a,
   input  logic [DATA_W-1:0]    i_b,
   input  logic [DATA_W-1:0]    i_c,
   input  logic [DATA_W-1:0]    i_d,
   input  logic [DATA_W-1:0]    i_e,
   input  logic [DATA_W-1:0]    i_f,
   input  logic [DATA_W-1:0]    i_g,
   input  logic [DATA_W-1:0]    i_h,
   input  logic                 i_out_ready,
   output logic                 o_out_valid,
   output logic [DATA_W-1:0]    o_out_data,
   output logic [NUM_PORTS-1:0] o_gnt,
   output logic [SEL_W-1:0]     o_sel,
   output logic                 o_busy,
   output logic                 o_cut
);

   state_t               r_state, w_state_nxt;
   logic [SEL_W-1:0]     r_ptr, w_ptr_nxt;
   logic [SEL_W-1:0]     r_sel, w_sel_nxt;
   logic [NUM_PORTS-1:0] r_gnt, w_gnt_nxt;
   logic                 r_cut, w_cut_nxt;
   logic                 w_load;
   logic                 w_beat;
   logic                 w_sel_req;
   logic                 w_sel_last;
   logic                 w_limit_hit;
   rr_pick_t             w_pick;

   assign w_pick      = rr_next(r_ptr, i_req);
   assign w_sel_req   = i_req[r_sel];
   assign w_sel_last  = i_last[r_sel];
   assign o_out_valid = (r_state == GRANT) && w_sel_req;
   assign w_beat      = o_out_valid && i_out_ready;
   assign w_load      = (r_state == IDLE) && w_pick.found;

   mux8way16 u_mux (
      .i_a   (i_a),
      .i_b   (i_b),
      .i_c   (i_c),
      .i_d   (i_d),
      .i_e   (i_e),
      .i_f   (i_f),
      .i_g   (i_g),
      .i_h   (i_h),
      .i_sel (r_sel),
      .o_y   (o_out_data)
   );

`ifdef ARB8WAY16_BURST_LIMIT_EN
   logic [7:0] r_beat_cnt, w_beat_cnt_nxt;

   // 9-bit compare so MAX_BEATS = 256 is reachable from an 8-bit count.
   assign w_limit_hit = w_beat && (({1'b0, r_beat_cnt} + 9'd1) == 9'(MAX_BEATS));

   always_comb begin
      w_beat_cnt_nxt = r_beat_cnt;
      if (w_load) begin
         w_beat_cnt_nxt = '0;
      end else if (w_beat) begin
         w_beat_cnt_nxt = r_beat_cnt + 8'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_beat_cnt <= '0;
      end else begin
         r_beat_cnt <= w_beat_cnt_nxt;
      end
   end
`else
   logic w_unused_max_beats;

   assign w_limit_hit        = 1'b0;
   assign w_unused_max_beats = ^9'(MAX_BEATS);
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_sel_nxt   = r_sel;
      w_gnt_nxt   = r_gnt;
      w_cut_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pick.found) begin
               w_state_nxt = GRANT;
               w_sel_nxt   = w_pick.idx;
               w_gnt_nxt   = {{(NUM_PORTS-1){1'b0}}, 1'b1} << w_pick.idx;
            end
         end
         GRANT: begin
            if (!w_sel_req || (w_beat && w_sel_last) || w_limit_hit) begin
               w_state_nxt = IDLE;
               w_ptr_nxt   = r_sel;
               w_gnt_nxt   = '0;
               // last wins over a coincident limit hit, so no cut then
               w_cut_nxt   = w_limit_hit && !w_sel_last;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_ptr   <= 3'd7;
         r_sel   <= '0;
         r_gnt   <= '0;
         r_cut   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_sel   <= w_sel_nxt;
         r_gnt   <= w_gnt_nxt;
         r_cut   <= w_cut_nxt;
      end
   end

   assign o_gnt  = r_gnt;
   assign o_sel  = r_sel;
   assign o_busy = (r_state == GRANT);
   assign o_cut  = r_cut;

endmodule

// File: tb/tb_arb8way16.sv
// Self-checking bench for arb8way16: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_arb8way16;

   localparam int TB_MAX = 4;
`ifdef ARB8WAY16_BURST_LIMIT_EN
   localparam bit LIMIT = 1'b1;
`else
   localparam bit LIMIT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  req;
   logic [7:0]  last;
   logic [15:0] d [8];
   logic        ready;

   logic        o_out_valid;
   logic [15:0] o_out_data;
   logic [7:0]  o_gnt;
   logic [2:0]  o_sel;
   logic        o_busy;
   logic        o_cut;

   int n_chk = 0;
   int n_err = 0;

   // behavioural model: who owns the channel, where the search resumes, beats so far
   bit m_busy;
   int m_port;
   int m_ptr;
   int m_cnt;
   bit m_cut;

   always #5 clk = ~clk;

   arb8way16 #(.MAX_BEATS(TB_MAX)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req       (req),
      .i_last      (last),
      .i_a         (d[0]),
      .i_b         (d[1]),
      .i_c         (d[2]),
      .i_d         (d[3]),
      .i_e         (d[4]),
      .i_f         (d[5]),
      .i_g         (d[6]),
      .i_h         (d[7]),
      .i_out_ready (ready),
      .o_out_valid (o_out_valid),
      .o_out_data  (o_out_data),
      .o_gnt       (o_gnt),
      .o_sel       (o_sel),
      .o_busy      (o_busy),
      .o_cut       (o_cut)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin : model
      bit nb;
      int np, nptr, nc;
      bit ncut, found;
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_port <= 0;
         m_ptr  <= 7;
         m_cnt  <= 0;
         m_cut  <= 1'b0;
      end else begin
         nb = m_busy; np = m_port; nptr = m_ptr; nc = m_cnt; ncut = 1'b0;
         if (!m_busy) begin
            found = 1'b0;
            for (int k = 1; k <= 8; k++) begin
               if (!found && req[(m_ptr + k) % 8]) begin
                  found = 1'b1;
                  np    = (m_ptr + k) % 8;
               end
            end
            if (found) begin
               nb = 1'b1;
               nc = 0;
            end
         end else if (!req[m_port]) begin
            nb = 1'b0; nptr = m_port;
         end else if (ready) begin
            nc = m_cnt + 1;
            if (last[m_port]) begin
               nb = 1'b0; nptr = m_port;
            end else if (LIMIT && nc == TB_MAX) begin
               nb = 1'b0; nptr = m_port; ncut = 1'b1;
            end
         end
         m_busy <= nb;
         m_port <= np;
         m_ptr  <= nptr;
         m_cnt  <= nc;
         m_cut  <= ncut;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("gnt",   32'(o_gnt),       m_busy ? 32'(1) << m_port : 32'(0));
         chk("sel",   32'(o_sel),       32'(m_port));
         chk("busy",  32'(o_busy),      32'(m_busy));
         chk("cut",   32'(o_cut),       32'(m_cut));
         chk("valid", 32'(o_out_valid), 32'(m_busy && req[m_port]));
         chk("data",  32'(o_out_data),  32'(d[m_port]));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      last  = '0;
      ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      req   = '0;
      last  = '0;
      ready = 1'b0;
      for (int i = 0; i < 8; i++) d[i] = 16'(16'h1000 + i);

      // reset state
      step();
      chk("rst_gnt",   32'(o_gnt),       32'h0);
      chk("rst_sel",   32'(o_sel),       32'h0);
      chk("rst_busy",  32'(o_busy),      32'h0);
      chk("rst_valid", 32'(o_out_valid), 32'h0);
      chk("rst_cut",   32'(o_cut),       32'h0);

      // single requester, three beats, last on the third
      do_reset();
      d[2] = 16'h1234; req = 8'h04; ready = 1'b1;
      step();
      chk("single_gnt",  32'(o_gnt),      32'h04);
      chk("single_sel",  32'(o_sel),      32'h2);
      chk("single_d1",   32'(o_out_data), 32'h1234);
      step();
      chk("single_d2",   32'(o_out_data), 32'h1234);
      step();
      last = 8'h04;
      #1;
      chk("single_v3",   32'(o_out_valid), 32'h1);
      chk("single_d3",   32'(o_out_data),  32'h1234);
      step();
      chk("single_rel",  32'(o_gnt),  32'h0);
      chk("single_busy", 32'(o_busy), 32'h0);
      req = '0; last = '0;
      step();

      // fairness with every port requesting single-beat bursts
      do_reset();
      req = 8'hFF; last = 8'hFF; ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         step();
         chk("fair_gnt", 32'(o_gnt), 32'(1) << (k % 8));
         chk("fair_sel", 32'(o_sel), 32'(k % 8));
         step();
         chk("fair_gap", 32'(o_gnt), 32'h0);
      end
      req = '0; last = '0;

      // backpressure on port 5, then beat limit with port 6 waiting
      do_reset();
      req = 8'h60; ready = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         chk("bp_gnt",   32'(o_gnt),       32'h20);
         chk("bp_valid", 32'(o_out_valid), 32'h1);
         if (i < 4) step();
      end
      step();
      ready = 1'b1;
      step();
      step();
      step();
      chk("lim_held", 32'(o_gnt), 32'h20);
      step();
`ifdef ARB8WAY16_BURST_LIMIT_EN
      chk("lim_rel", 32'(o_gnt), 32'h0);
      chk("lim_cut", 32'(o_cut), 32'h1);
      step();
      chk("lim_next", 32'(o_gnt), 32'h40);
      chk("lim_cut0", 32'(o_cut), 32'h0);
`else
      chk("nolim_gnt", 32'(o_gnt), 32'h20);
      chk("nolim_cut", 32'(o_cut), 32'h0);
      step();
      chk("nolim_gnt2", 32'(o_gnt), 32'h20);
`endif

      // abandon: port 3 drops request after two beats
      do_reset();
      req = 8'h08; ready = 1'b1;
      step();
      chk("ab_gnt", 32'(o_gnt), 32'h08);
      step();
      step();
      req = 8'h01;
      #1;
      chk("ab_valid", 32'(o_out_valid), 32'h0);
      step();
      chk("ab_rel", 32'(o_gnt), 32'h0);
      step();
      chk("ab_next", 32'(o_gnt), 32'h01);
      chk("ab_sel",  32'(o_sel), 32'h0);

      // asynchronous reset mid-burst
      do_reset();
      req = 8'h04; ready = 1'b0;
      step();
      chk("mr_gnt", 32'(o_gnt), 32'h04);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mr_gnt0",  32'(o_gnt),       32'h0);
      chk("mr_sel0",  32'(o_sel),       32'h0);
      chk("mr_busy0", 32'(o_busy),      32'h0);
      chk("mr_val0",  32'(o_out_valid), 32'h0);
      req = 8'h82;
      step();
      rst_n = 1'b1;
      step();
      chk("mr_first", 32'(o_gnt), 32'h02);

      // randomized traffic
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         for (int i = 0; i < 8; i++) d[i] = 16'($urandom);
         if ($urandom_range(7) == 0) req = 8'($urandom);
         last  = 8'($urandom) & 8'($urandom);
         ready = ($urandom_range(3) != 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/arb8way16.md
# arb8way16

Round-robin arbiter and sequencer that shares one 16-bit output channel among eight requesters. It instantiates the team's 8-way 16-bit multiplexer as its datapath and drives the mux select from a registered grant. Each grant covers a multi-beat burst under a valid/ready handshake. The block sits between eight producer ports and a single downstream consumer.

## Interface
- MAX_BEATS, 16, maximum beats per grant when the burst limit is compiled in; legal range 2..256
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  8  per-requester request; bit i belongs to requester i
- last  input  8  per-requester end-of-burst flag, sampled on a beat by the granted requester
- a..h  input  16 each  requester data for ports 0..7
- out_ready  input  1  consumer accepts the current beat
- out_valid  output  1  beat present on out_data
- out_data  output  16  selected requester data
- gnt  output  8  one-hot grant, registered; all zero when idle
- sel  output  3  binary index of the granted port, registered
- busy  output  1  high while in GRANT
- cut  output  1  one-cycle pulse when a burst is force-ended by the limit

## Operation
- Two states: IDLE and GRANT.
- Reset values: state IDLE; ptr = 7; gnt = 0; sel = 0; busy = 0; cut = 0; beat counter = 0; out_valid = 0.
- IDLE with req != 0: the winner is the first set bit searching ptr+1, ptr+2, … modulo 8, wrapping 7 to 0. The next cycle loads gnt = onehot(winner), loads sel = winner, clears the beat counter, and enters GRANT.
- IDLE with req == 0: the block stays in IDLE.
- GRANT:
  - out_valid = req[sel].
  - out_data = the mux output at sel, always.
  - A beat is a cycle with out_valid & out_ready.
- Release from GRANT to IDLE takes effect at the next edge. On release: ptr ← sel, gnt ← 0, busy ← 0. Release occurs on any of:
  - a beat with last[sel] = 1;
  - req[sel] = 0, which abandons the burst (no beat occurs in that cycle);
  - a burst-limit hit, when the limit is compiled in.
- Non-granted req and last bits are ignored during GRANT.
- Backpressure: out_ready = 0 holds gnt, sel and the counter unchanged, and counts no beat.
- Simultaneous last and limit hit in the same beat: release once; cut = 0, because last takes precedence.
- Reset asserted mid-burst: all state clears immediately and asynchronously. The first grant after reset goes to the lowest-index requesting port.

## Timing
- Grant latency: req seen in IDLE at edge N → gnt and sel valid after edge N+1. out_valid can rise in that same cycle.
- out_valid and out_data are combinational from registered sel and the live req and data inputs. There is no added data latency.
- Release bubble: a last beat at cycle M → gnt = 0 in cycle M+1 → earliest next grant in cycle M+2.
- Minimum period per single-beat grant is 2 cycles, giving a peak throughput of 50% for single-beat traffic.
- cut is high for exactly the cycle after the limiting beat, together with gnt = 0.

## Configuration
- ARB8WAY16_BURST_LIMIT_EN defined:
  - an 8-bit beat counter increments on every beat in GRANT;
  - the beat that makes the count equal MAX_BEATS forces release and pulses cut.
- ARB8WAY16_BURST_LIMIT_EN undefined:
  - no counter is built, cut is tied to 0, and grants last until last or req drop;
  - MAX_BEATS is unused.

## Structure
- Shared package arb8way16_pkg:
  - state enum (IDLE, GRANT);
  - NUM_PORTS = 8, DATA_W = 16, SEL_W = 3;
  - the round-robin next-winner function (ptr, req → index, found).
- One sub-module, mux8way16: the existing combinational 8-input 16-bit mux, instantiated once with sel driving its select. The arbiter adds no other datapath logic.

## Test plan
- Reset: assert rst_n = 0 mid-burst with gnt = 8'h04 → gnt = 0, sel = 0, busy = 0, out_valid = 0 immediately. First grant after release with req = 8'h82 → gnt = 8'h02.
- Single requester: req = 8'h04, c = 16'h1234, out_ready = 1, last[2] asserted on the 3rd beat → gnt = 8'h04 one cycle after req, three beats of 16'h1234, gnt = 0 the cycle after the 3rd beat.
- Fairness: req = 8'hFF and last = 8'hFF held constant → grant sequence 0,1,2,…,7,0 with one grant every 2 cycles; sel matches each grant.
- Backpressure: granted port 5, out_ready = 0 for 5 cycles → gnt = 8'h20 held, out_valid = 1, no release, counter unchanged.
- Burst limit (macro defined, MAX_BEATS = 4): ports 5 and 6 requesting, last = 0 → cut pulses after 4 beats on port 5, next grant is port 6. With the macro undefined the same stimulus never releases port 5.
- Abandon: port 3 granted, req[3] drops after 2 beats while req[0] = 1 → gnt = 0 in the next cycle, then grant goes to port 0 with ptr = 3.
